// File: rtl/upcnt_ctrl.sv
// ============================================================================
// upcnt_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Sequencer for a WIDTH-bit structural up counter. A run works like this:
//   clear the counter, enable it one clock at a time until it reaches the
//   captured target, then pulse done. While a run is active the sequencer
//   can pause, abort, or reload automatically. It also counts completed runs.
//
// Ports:
//   i_clk        rising-edge clock
//   i_s_reset    synchronous reset, active-low
//   i_go         start request, only honoured while idle
//   i_pause      level, holds the count while high
//   i_abort      level, returns to idle; wins over everything else
//   i_reload     restart automatically after done (looked at only in DONE)
//   i_target     terminal count, captured when go is accepted
//   i_cnt_value  current counter output
//   o_cnt_en     counter increment enable
//   o_cnt_clr    one-cycle counter clear
//   o_busy       high whenever the sequencer is not idle
//   o_done       one-cycle pulse while in DONE
//   o_cfg_err    one-cycle pulse after a go with target==0
//   o_periods    completed runs since the last accepted go (saturating)
// ============================================================================
module upcnt_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_s_reset,
    input  logic              i_go,
    input  logic              i_pause,
    input  logic              i_abort,
    input  logic              i_reload,
    input  logic [WIDTH-1:0]  i_target,
    input  logic [WIDTH-1:0]  i_cnt_value,
    output logic              o_cnt_en,
    output logic              o_cnt_clr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err,
    output logic [PCNT_W-1:0] o_periods
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [WIDTH-1:0]    r_tgtQ;
    logic [PCNT_W-1:0]   r_periods;
    logic                r_cfgErr;

    logic                w_goAccept;
    logic                w_goBadTarget;
    logic                w_lastCount;
    logic                w_periodsFull;

    // A go is only considered in IDLE. Abort has priority, so a go that
    // arrives together with abort is neither accepted nor flagged.
    assign w_goAccept    = (r_state == IDLE) & i_go & ~i_abort & (i_target != '0);
    assign w_goBadTarget = (r_state == IDLE) & i_go & ~i_abort & (i_target == '0);

    // The increment that happens on this edge brings the counter to the
    // target, so the FSM must reach DONE on the same edge.
    assign w_lastCount   = (i_cnt_value == (r_tgtQ - WIDTH'(1)));

    assign w_periodsFull = (r_periods == '1);

    // State register. Reset returns to IDLE. It does not touch the external
    // counter, so the count stays where it was.
    always_ff @(posedge i_clk) begin
        if (!i_s_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Run configuration and status registers. The target is captured only on
    // an accepted go, so later changes to i_target during a run have no effect.
    // The period count clears on each new run and saturates rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_s_reset) begin
            r_tgtQ    <= '0;
            r_periods <= '0;
            r_cfgErr  <= 1'b0;
        end else begin
            r_cfgErr <= w_goBadTarget;
            if (w_goAccept) begin
                r_tgtQ    <= i_target;
                r_periods <= '0;
            end else if (r_state == DONE && !w_periodsFull) begin
                r_periods <= r_periods + PCNT_W'(1);
            end
        end
    end

    // Next-state logic. In every busy state abort is checked first. Pause
    // ranks above terminal-count detection, so a run paused on its last
    // increment resumes before it finishes.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_goAccept) begin
                    w_nextState = CLEAR;
                end
            end
            CLEAR: begin
                w_nextState = i_abort ? IDLE : RUN;
            end
            RUN: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else if (i_pause) begin
                    w_nextState = PAUSE;
                end else if (w_lastCount) begin
                    w_nextState = DONE;
                end
            end
            PAUSE: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else if (!i_pause) begin
                    w_nextState = RUN;
                end
            end
            DONE: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else if (i_reload) begin
                    w_nextState = CLEAR;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output decode. Every output is a pure function of the state except the
    // counter enable. The enable also looks at pause and abort so that the
    // count stops on the same edge the FSM leaves RUN.
    always_comb begin
        o_cnt_en  = 1'b0;
        o_cnt_clr = 1'b0;
        o_busy    = (r_state != IDLE);
        o_done    = 1'b0;
        case (r_state)
            CLEAR:   o_cnt_clr = 1'b1;
            RUN:     o_cnt_en  = ~i_pause & ~i_abort;
            DONE:    o_done    = 1'b1;
            default: ;
        endcase
    end

    assign o_cfg_err = r_cfgErr;
    assign o_periods = r_periods;

endmodule

// File: tb/tb_upcnt_ctrl.sv
// ============================================================================
// tb_upcnt_ctrl
// ----------------------------------------------------------------------------
// This bench drives upcnt_ctrl together with a behavioural 4-bit counter.
// Each job works out when its done pulses should appear, using run-level
// arithmetic:
//   - A go accepted at edge E gives the first done in the cycle after
//     edge E+tgt+1.
//   - A pause window that covers N edges of RUN adds N+1 cycles.
//   - Each reload adds tgt+2 cycles.
// Expected done and cfg_err events go into queues. A monitor on the falling
// edge pops an entry each time the DUT raises one of these outputs.
// ============================================================================
module tb_upcnt_ctrl;

    localparam int WIDTH  = 4;
    localparam int PCNT_W = 8;
    localparam int PMAX   = (1 << PCNT_W) - 1;

    logic              clk = 1'b0;
    logic              sReset = 1'b0;
    logic              go = 1'b0;
    logic              pause = 1'b0;
    logic              abort = 1'b0;
    logic              reload = 1'b0;
    logic [WIDTH-1:0]  target = '0;
    logic [WIDTH-1:0]  cntVal = '0;
    logic              cntEn;
    logic              cntClr;
    logic              busy;
    logic              done;
    logic              cfgErr;
    logic [PCNT_W-1:0] periods;

    int cyc = 0;
    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        int cyc;
        int cnt;
        int per;
    } doneEv_t;

    doneEv_t doneQ[$];
    int      cfgQ[$];

    upcnt_ctrl #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
        .i_clk       (clk),
        .i_s_reset   (sReset),
        .i_go        (go),
        .i_pause     (pause),
        .i_abort     (abort),
        .i_reload    (reload),
        .i_target    (target),
        .i_cnt_value (cntVal),
        .o_cnt_en    (cntEn),
        .o_cnt_clr   (cntClr),
        .o_busy      (busy),
        .o_done      (done),
        .o_cfg_err   (cfgErr),
        .o_periods   (periods)
    );

    // Free-running clock plus an edge counter. The counter names the cycle
    // that follows each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural up counter. Clear wins over enable. Controller reset does
    // not touch it.
    always @(posedge clk) begin
        if (cntClr) begin
            cntVal <= '0;
        end else if (cntEn) begin
            cntVal <= cntVal + 4'd1;
        end
    end

    // Safety net. If the run ever stalls, report it and stop.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor. Each done or cfg_err pulse must match the oldest expected
    // event: the cycle it appears in, the count at that moment, and the
    // periods value shown during DONE.
    always @(negedge clk) begin
        doneEv_t ev;
        int      expCyc;
        if (done === 1'b1) begin
            nCompared++;
            if (doneQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL done_unexpected: done high at cycle %0d, expected no done", cyc);
            end else begin
                ev = doneQ.pop_front();
                if (cyc != ev.cyc || int'(cntVal) != ev.cnt || int'(periods) != ev.per) begin
                    nMismatched++;
                    $display("[TB] FAIL done_event: got cycle %0d count %0d periods %0d, expected cycle %0d count %0d periods %0d",
                             cyc, cntVal, periods, ev.cyc, ev.cnt, ev.per);
                end
            end
        end
        if (cfgErr === 1'b1) begin
            nCompared++;
            if (cfgQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL cfg_unexpected: cfg_err high at cycle %0d, expected low", cyc);
            end else begin
                expCyc = cfgQ.pop_front();
                if (cyc != expCyc) begin
                    nMismatched++;
                    $display("[TB] FAIL cfg_event: got cycle %0d, expected cycle %0d", cyc, expCyc);
                end
            end
        end
    end

    // One complete job, starting from idle:
    //   tgt == 0        only a cfg_err is expected.
    //   abortOff >= 0   abort is applied at RUN edge offset abortOff.
    //   otherwise       an optional pause window (pStart, pLen) in the first
    //                   period, followed by nReload automatic restarts.
    // While busy, go and target are randomised; the controller must ignore them.
    task automatic applyStimulus(input int tgt, input int pStart, input int pLen,
                                 input int nReload, input int abortOff);
        int      startEdge;
        int      endEdge;
        int      abortEdge;
        int      dCyc;
        int      n;
        doneEv_t ev;

        pause  = 1'b0;
        abort  = 1'b0;
        reload = (nReload > 0);
        target = 4'(tgt);
        go     = 1'b1;
        step();
        startEdge = cyc;
        go = 1'b0;

        if (tgt == 0) begin
            cfgQ.push_back(startEdge);
            step();
            checkOutput("cfg_busy", int'(busy), 0);
            checkOutput("cfg_pending", cfgQ.size(), 0);
            return;
        end

        abortEdge = -1;
        if (abortOff >= 0) begin
            abortEdge = startEdge + 2 + abortOff;
            endEdge   = abortEdge;
        end else begin
            dCyc = startEdge + tgt + 1 + ((pLen > 0) ? pLen + 1 : 0);
            ev.cyc = dCyc; ev.cnt = tgt; ev.per = 0;
            doneQ.push_back(ev);
            for (int r = 1; r <= nReload; r++) begin
                dCyc += tgt + 2;
                ev.cyc = dCyc; ev.cnt = tgt; ev.per = (r > PMAX) ? PMAX : r;
                doneQ.push_back(ev);
            end
            endEdge = dCyc + 1;
        end

        while (cyc < endEdge) begin
            n = cyc + 1;
            pause  = (pLen > 0) && (n >= startEdge + 2 + pStart) && (n < startEdge + 2 + pStart + pLen);
            abort  = (n == abortEdge);
            reload = (nReload > 0) && (n < endEdge);
            go     = ($urandom_range(0, 3) == 0);
            target = 4'($urandom_range(0, 15));
            step();
        end
        go     = 1'b0;
        pause  = 1'b0;
        abort  = 1'b0;
        reload = 1'b0;

        checkOutput("end_busy", int'(busy), 0);
        if (abortOff >= 0) begin
            checkOutput("abort_count_held", int'(cntVal), abortOff);
            checkOutput("abort_periods", int'(periods), 0);
            step();
            checkOutput("abort_count_still", int'(cntVal), abortOff);
        end else begin
            checkOutput("end_periods", int'(periods), (nReload + 1 > PMAX) ? PMAX : nReload + 1);
            checkOutput("done_missing", doneQ.size(), 0);
        end
    endtask

    // Main sequence: reset, the directed scenarios, a reset in the middle of
    // a run, a saturation run, then randomised jobs.
    initial begin
        int tgt;
        int kind;
        int ps;
        int pl;

        sReset = 1'b0;
        step();
        step();
        checkOutput("reset_cnt_en",  int'(cntEn),   0);
        checkOutput("reset_cnt_clr", int'(cntClr),  0);
        checkOutput("reset_busy",    int'(busy),    0);
        checkOutput("reset_done",    int'(done),    0);
        checkOutput("reset_cfg_err", int'(cfgErr),  0);
        checkOutput("reset_periods", int'(periods), 0);
        sReset = 1'b1;
        step();

        applyStimulus(5, 0, 0, 0, -1);
        applyStimulus(3, 1, 4, 0, -1);
        applyStimulus(2, 0, 0, 2, -1);
        applyStimulus(9, 0, 0, 0, 4);
        applyStimulus(0, 0, 0, 0, -1);
        applyStimulus(15, 0, 0, 0, -1);
        applyStimulus(15, 14, 2, 1, -1);

        // Reset in the middle of a run: the controller must be idle on the
        // next edge, and no done may follow.
        target = 4'd9;
        go = 1'b1;
        step();
        go = 1'b0;
        repeat (4) step();
        checkOutput("midrun_busy_before", int'(busy), 1);
        sReset = 1'b0;
        step();
        sReset = 1'b1;
        checkOutput("midrun_busy", int'(busy), 0);
        checkOutput("midrun_cnt_en", int'(cntEn), 0);
        checkOutput("midrun_periods", int'(periods), 0);
        repeat (12) step();
        checkOutput("midrun_idle", int'(busy), 0);

        applyStimulus(1, 0, 0, 257, -1);

        for (int j = 0; j < 30; j++) begin
            tgt  = $urandom_range(1, 15);
            kind = $urandom_range(0, 4);
            ps   = $urandom_range(0, tgt - 1);
            pl   = $urandom_range(1, 4);
            case (kind)
                0: applyStimulus(tgt, 0, 0, 0, -1);
                1: applyStimulus(tgt, ps, pl, 0, -1);
                2: applyStimulus(tgt, ps, pl, $urandom_range(1, 3), -1);
                3: applyStimulus(tgt, 0, 0, 0, ps);
                default: applyStimulus(0, 0, 0, 0, -1);
            endcase
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (3) step();
        checkOutput("final_done_queue", doneQ.size(), 0);
        checkOutput("final_cfg_queue", cfgQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
